// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Video timing source for the HDMI pipeline. It produces the {Vblank, Hblank} and
//   {D_sync, Vsync, Hsync} bundle, plus the pixel coordinates of the position that the
//   bundle describes. All outputs are registered from the same next-position decode,
//   so no output is skewed against another. The run/stop sequencing never truncates
//   a frame.
//
// Ports
//   clk_i          pixel clock
//   rst_ni         synchronous active-low reset (acts regardless of cen_i)
//   cen_i          video clock enable; all state advances only when high
//   en_i           run request (level)
//   vh_blank_o     {Vblank, Hblank}
//   dvh_sync_o     {D_sync, Vsync, Hsync}; D_sync = active-video data enable
//   pix_x_o        current horizontal position h
//   pix_y_o        current vertical position v
//   frame_start_o  high while position = (0,0) and running
//   running_o      high in RUN or STOP_PEND
module video_timing_gen #(
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned H_FP       = 88,
    parameter int unsigned H_SYNC     = 44,
    parameter int unsigned H_BP       = 148,
    parameter int unsigned V_ACTIVE   = 1080,
    parameter int unsigned V_FP       = 4,
    parameter int unsigned V_SYNC     = 5,
    parameter int unsigned V_BP       = 36,
    parameter int unsigned H_SYNC_POL = 1,
    parameter int unsigned V_SYNC_POL = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    input  logic        en_i,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [11:0] pix_x_o,
    output logic [11:0] pix_y_o,
    output logic        frame_start_o,
    output logic        running_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4095) begin : g_h_total_chk
            $error("video_timing_gen: H_TOTAL exceeds 4095");
        end
        if (V_TOTAL > 4095) begin : g_v_total_chk
            $error("video_timing_gen: V_TOTAL exceeds 4095");
        end
    endgenerate

    localparam logic [11:0] HActive    = 12'(H_ACTIVE);
    localparam logic [11:0] HSyncStart = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HSyncEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HLast      = 12'(H_TOTAL - 1);
    localparam logic [11:0] VActive    = 12'(V_ACTIVE);
    localparam logic [11:0] VSyncStart = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VSyncEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VLast      = 12'(V_TOTAL - 1);

    localparam logic HPol = (H_SYNC_POL != 0);
    localparam logic VPol = (V_SYNC_POL != 0);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StRun      = 2'd1;
    localparam logic [1:0] StStopPend = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [1:0]  vh_blank_q, vh_blank_d;
    logic [2:0]  dvh_sync_q, dvh_sync_d;
    logic        frame_start_q, frame_start_d;
    logic        running_q, running_d;

    logic        h_last, v_last;
    logic [11:0] v_adj;
    logic        hblank, hsync_act, vblank, vsync_act;

    assign h_last = (h_q == HLast);
    assign v_last = (v_q == VLast);

    // Next state and next position.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (cen_i) begin
            unique case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_d = StRun;
                    end
                end
                StRun, StStopPend: begin
                    h_d = h_last ? 12'd0 : h_q + 12'd1;
                    if (h_last) begin
                        v_d = v_last ? 12'd0 : v_q + 12'd1;
                    end
                    // A stop request only takes effect once the last pixel of the frame
                    // has been emitted; the counters wrap to (0,0) for the idle hold.
                    if (h_last && v_last && !en_i) begin
                        state_d = StIdle;
                    end else begin
                        state_d = en_i ? StRun : StStopPend;
                    end
                end
                default: begin
                    state_d = StIdle;
                    h_d     = 12'd0;
                    v_d     = 12'd0;
                end
            endcase
        end
    end

    // Decode of the next position. Vertical flags switch at the Hblank rising edge, so
    // the line index is advanced by one from h = H_ACTIVE onwards.
    always_comb begin
        v_adj = v_d;
        if (h_d >= HActive) begin
            v_adj = (v_d == VLast) ? 12'd0 : v_d + 12'd1;
        end
        hblank    = (h_d >= HActive);
        hsync_act = (h_d >= HSyncStart) && (h_d < HSyncEnd);
        vblank    = (v_adj >= VActive);
        vsync_act = (v_adj >= VSyncStart) && (v_adj < VSyncEnd);

        running_d = (state_d != StIdle);
        if (running_d) begin
            vh_blank_d    = {vblank, hblank};
            dvh_sync_d    = {~hblank & ~vblank, vsync_act ~^ VPol, hsync_act ~^ HPol};
            frame_start_d = (h_d == 12'd0) && (v_d == 12'd0);
        end else begin
            vh_blank_d    = 2'b11;
            dvh_sync_d    = {1'b0, ~VPol, ~HPol};
            frame_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            vh_blank_q    <= 2'b11;
            dvh_sync_q    <= {1'b0, ~VPol, ~HPol};
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else if (cen_i) begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            vh_blank_q    <= vh_blank_d;
            dvh_sync_q    <= dvh_sync_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign vh_blank_o    = vh_blank_q;
    assign dvh_sync_o    = dvh_sync_q;
    assign pix_x_o       = h_q;
    assign pix_y_o       = v_q;
    assign frame_start_o = frame_start_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    logic        clk;
    logic        rst_n, cen, en;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic [11:0] pix_x, pix_y;
    logic        frame_start, running;

    logic        d_rst_n, d_cen, d_en;
    logic [1:0]  d_vh_blank;
    logic [2:0]  d_dvh_sync;
    logic [11:0] d_pix_x, d_pix_y;
    logic        d_frame_start, d_running;

    int tests = 0;
    int fails = 0;

    // Small timing: H 8/2/3/3 (16 total), V 4/1/2/1 (8 total).
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cen_i        (cen),
        .en_i         (en),
        .vh_blank_o   (vh_blank),
        .dvh_sync_o   (dvh_sync),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .frame_start_o(frame_start),
        .running_o    (running)
    );

    // Default 1080p timing.
    video_timing_gen dut_d (
        .clk_i        (clk),
        .rst_ni       (d_rst_n),
        .cen_i        (d_cen),
        .en_i         (d_en),
        .vh_blank_o   (d_vh_blank),
        .dvh_sync_o   (d_dvh_sync),
        .pix_x_o      (d_pix_x),
        .pix_y_o      (d_pix_y),
        .frame_start_o(d_frame_start),
        .running_o    (d_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {Vblank, Hblank, D_sync, Vsync, Hsync} for the small timing, using a
    // linear pixel index (16 pixels per line) for the vertical boundaries.
    function automatic logic [4:0] exp_sig(input int x, input int y);
        int   idx;
        logic hb, hs, vb, vs, de;
        idx = y * 16 + x;
        hb  = (x >= 8);
        hs  = (x >= 10) && (x <= 12);
        vb  = (idx >= 56) && (idx < 120);   // (8,3) .. before (8,7)
        vs  = (idx >= 72) && (idx < 104);   // (8,4) .. before (8,6)
        de  = !hb && !vb;
        return {vb, hb, de, vs, hs};
    endfunction

    initial begin
        int dcount, notrun, cnt, viol, rise1, rise2, nrise, hs_cnt, hs_first;
        logic        fs_prev, hs_prev, found;
        logic [30:0] prev_bundle, cur_bundle;

        rst_n = 1'b0; cen = 1'b1; en = 1'b1;
        d_rst_n = 1'b0; d_cen = 1'b1; d_en = 1'b1;

        // Reset held three cycles with en high.
        repeat (3) step();
        check("rst_vh_blank", 32'(vh_blank), 32'h3);
        check("rst_dvh_sync", 32'(dvh_sync), 32'h0);
        check("rst_pix", 32'({pix_x, pix_y}), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);

        // First frame, every pixel checked.
        rst_n = 1'b1;
        step();
        dcount = 0;
        for (int i = 0; i < 128; i++) begin
            check("frame_pix", 32'({pix_x, pix_y}), 32'({12'(i % 16), 12'(i / 16)}));
            check("frame_sig", 32'({vh_blank, dvh_sync}), 32'(exp_sig(i % 16, i / 16)));
            check("frame_fs", 32'(frame_start), 32'(i == 0));
            check("frame_run", 32'(running), 32'h1);
            dcount += int'(dvh_sync[2]);
            step();
        end
        check("dsync_count", 32'(dcount), 32'd32);
        check("fs_period_128", 32'(frame_start), 32'h1);
        check("wrap_pix", 32'({pix_x, pix_y}), 32'h0);

        // Stop request mid-frame at (5,2): the frame completes, then idle.
        repeat (37) step();
        check("stop_at_pix", 32'({pix_x, pix_y}), 32'({12'd5, 12'd2}));
        en = 1'b0;
        notrun = 0;
        for (int i = 37; i < 128; i++) begin
            if (!running) notrun++;
            step();
        end
        check("stop_run_held", 32'(notrun), 32'd0);
        check("stop_idle_run", 32'(running), 32'h0);
        check("stop_idle_blank", 32'(vh_blank), 32'h3);
        check("stop_idle_sync", 32'(dvh_sync), 32'h0);
        check("stop_idle_pix", 32'({pix_x, pix_y}), 32'h0);
        repeat (3) step();
        check("idle_hold_run", 32'(running), 32'h0);
        check("idle_hold_fs", 32'(frame_start), 32'h0);

        // Start, drop at (5,2), re-raise at (0,5): no gap in the frame cadence.
        en = 1'b1;
        step();
        check("restart_fs", 32'(frame_start), 32'h1);
        check("restart_pix", 32'({pix_x, pix_y}), 32'h0);
        repeat (37) step();
        en = 1'b0;
        repeat (43) step();
        check("resume_pix", 32'({pix_x, pix_y}), 32'({12'd0, 12'd5}));
        check("resume_run", 32'(running), 32'h1);
        en = 1'b1;
        cnt = 80;
        do begin
            step();
            cnt++;
        end while (!frame_start && cnt < 400);
        check("resume_fs_period", 32'(cnt), 32'd128);

        // Clock enable high one of every three clocks.
        viol = 0; nrise = 0; rise1 = 0; rise2 = 0;
        fs_prev = frame_start;
        for (int k = 0; k < 1200; k++) begin
            cen = (k % 3 == 0);
            prev_bundle = {vh_blank, dvh_sync, pix_x, pix_y, frame_start, running};
            step();
            cur_bundle = {vh_blank, dvh_sync, pix_x, pix_y, frame_start, running};
            if (!cen && cur_bundle !== prev_bundle) viol++;
            if (frame_start && !fs_prev) begin
                nrise++;
                if (nrise == 1) rise1 = k;
                if (nrise == 2) rise2 = k;
            end
            fs_prev = frame_start;
        end
        cen = 1'b1;
        check("cen_frozen", 32'(viol), 32'd0);
        check("cen_first_fs", 32'(rise1), 32'd381);
        check("cen_period", 32'(rise2 - rise1), 32'd384);

        // Reset at (9,6) while cen is low.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (pix_x == 12'd9 && pix_y == 12'd6) found = 1'b1;
            else step();
        end
        check("reach_9_6", 32'(found), 32'h1);
        cen = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst_blank", 32'(vh_blank), 32'h3);
        check("midrst_sync", 32'(dvh_sync), 32'h0);
        check("midrst_pix", 32'({pix_x, pix_y}), 32'h0);
        check("midrst_run", 32'(running), 32'h0);
        rst_n = 1'b1;
        cen = 1'b1;
        step();
        check("midrst_restart_fs", 32'(frame_start), 32'h1);
        check("midrst_restart_sig", 32'({vh_blank, dvh_sync}), 32'h04);
        step();
        check("midrst_next_pix", 32'({pix_x, pix_y}), 32'({12'd1, 12'd0}));

        // Default 1080p timing: first line.
        d_rst_n = 1'b1;
        step();
        check("d_fs", 32'(d_frame_start), 32'h1);
        check("d_sig_origin", 32'({d_vh_blank, d_dvh_sync}), 32'h04);
        hs_cnt = 0; dcount = 0; hs_first = 0; hs_prev = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            hs_cnt += int'(d_dvh_sync[0]);
            dcount += int'(d_dvh_sync[2]);
            if (d_dvh_sync[0] && !hs_prev) hs_first = int'(d_pix_x);
            hs_prev = d_dvh_sync[0];
            if (i == 1919) check("d_last_active", 32'(d_vh_blank), 32'h0);
            if (i == 1920) check("d_hblank_rise", 32'(d_vh_blank), 32'h1);
            step();
        end
        check("d_hsync_width", 32'(hs_cnt), 32'd44);
        check("d_hsync_start", 32'(hs_first), 32'd2008);
        check("d_dsync_line", 32'(dcount), 32'd1920);
        check("d_line1_pix", 32'({d_pix_x, d_pix_y}), 32'({12'd0, 12'd1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Video timing source for the HDMI pipeline. Generates the vh_blank / dvh_sync timing bundle and pixel coordinates that the per-pixel overlay stages consume. Default timing is 1920x1080p (2200 x 1125 total). Run/stop control is sequenced so that output frames are never truncated.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
H_SYNC_POL, 1, 1 = hsync active-high
V_SYNC_POL, 1, 1 = vsync active-high

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  synchronous, active-low reset
cen_i  in  1  video clock enable; all state advances only when high
en_i  in  1  run request (level)
vh_blank_o  out  2  {Vblank, Hblank}
dvh_sync_o  out  3  {D_sync, Vsync, Hsync}; D_sync = active-video data enable
pix_x_o  out  12  current horizontal position h
pix_y_o  out  12  current vertical position v
frame_start_o  out  1  high while position = (0,0) and running
running_o  out  1  high in RUN or STOP_PEND

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4095; elaboration fails otherwise.
- Reset:
  - Takes effect on any clock edge with rst_ni = 0, regardless of cen_i.
  - Goes to IDLE, h = v = 0.
  - Outputs: vh_blank_o = 2'b11; D_sync = 0; Hsync/Vsync at inactive level (~H_SYNC_POL / ~V_SYNC_POL); pix_x_o = pix_y_o = 0; frame_start_o = 0; running_o = 0.
- State machine: IDLE, RUN, STOP_PEND. Transitions are evaluated only on cen_i = 1.
  - IDLE → RUN when en_i = 1. The next cen cycle presents position (0,0).
  - RUN → STOP_PEND when en_i = 0.
  - STOP_PEND → RUN when en_i = 1 again. Counting continues uninterrupted.
  - STOP_PEND → IDLE on the cen cycle at position (H_TOTAL-1, V_TOTAL-1). A frame always completes.
  - In RUN or STOP_PEND at the last frame pixel with en_i = 1: wrap to (0,0) and stay in RUN.
- Counters (RUN / STOP_PEND, cen_i = 1):
  - h increments and wraps from H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps from V_TOTAL-1 to 0.
  - In IDLE, counters hold at 0 and outputs hold their reset levels.
- Decode: all outputs are registered and describe the same (h,v) shown on pix_x_o / pix_y_o. There is no skew between signals.
  - Hblank = (h ≥ H_ACTIVE).
  - Hsync active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - Vblank changes at the hblank rising edge, not at line start. It rises at (H_ACTIVE, V_ACTIVE-1) and falls at (H_ACTIVE, V_TOTAL-1). Downstream frame-start detection relies on Hblank and Vblank rising on the same cycle.
  - Vsync follows the same alignment: active from (H_ACTIVE, V_ACTIVE+V_FP-1) to (H_ACTIVE, V_ACTIVE+V_FP+V_SYNC-1).
  - D_sync = ~Hblank & ~Vblank.
  - frame_start_o = (h = 0 & v = 0) while running.
- cen_i = 0: every register holds, and outputs are frozen unchanged. Consumers qualify with cen_i.
- Output latency: a state change on a cen cycle is visible on the outputs after the same clock edge.

Test Plan:
1. Reset: hold rst_ni = 0 for 3 cycles with en_i = 1 → vh_blank_o = 11, dvh_sync_o = 000 (default polarity), pix 0/0, running_o = 0.
2. Small timing (H 8/2/3/3 → H_TOTAL 16; V 4/1/2/1 → V_TOTAL 8), cen_i = 1, en_i = 1:
   - Hblank high exactly for h = 8..15; Hsync for h = 10..12.
   - Hblank and Vblank rise together at (8,3); Vblank falls at (8,7).
   - Vsync spans (8,4) to (7,6).
   - D_sync high for 32 cycles per frame.
   - frame_start_o every 128 cycles.
3. Stop/resume (small timing):
   - Drop en_i at (5,2) → running_o stays 1 through (15,7), then IDLE with blanks 11.
   - Drop en_i at (5,2) and re-raise at (0,5) → no gap; next frame_start_o at exactly 128 cycles after the previous one.
4. Clock enable: cen_i high 1 of 3 cycles → every output change only on enabled edges; frame period = 384 clocks.
5. Reset mid-frame at (9,6) with cen_i = 0 → reset values on the next edge; restart from (0,0) after rst_ni = 1.
6. Default parameters: frame_start_o spacing = 2,475,000 cen cycles; D_sync count per frame = 2,073,600; Hsync width = 44 cycles.
